// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage: internal data memory with word/half/byte access,
// plus the M/W pipeline register feeding write-back and store-data forwarding.
module mem_wb_stage #(
  parameter int DM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC8_M,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Res_M,
  output logic [31:0] IR_W,
  output logic [31:0] AO_W,
  output logic [31:0] DR_WD,
  output logic [31:0] PC8_W,
  output logic [4:0]  A3_W,
  output logic [1:0]  Res_W
);
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0]      r_dm [2**DM_AW];
  logic [5:0]       w_op;
  logic [DM_AW-1:0] w_idx;
  logic [31:0]      w_word;
  logic [31:0]      w_wdata;
  logic             w_we;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic [31:0]      w_ld;

  assign w_op   = IR_M[31:26];
  // High address bits are dropped so accesses wrap modulo the memory size.
  assign w_idx  = AO_M[DM_AW+1:2];
  assign w_word = r_dm[w_idx];

  // Read-modify-write merge so partial stores keep the untouched lanes.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = w_word;
    case (w_op)
      OP_SW: begin
        w_we    = 1'b1;
        w_wdata = WriteData;
      end
      OP_SH: begin
        w_we = 1'b1;
        if (AO_M[1]) w_wdata[31:16] = WriteData[15:0];
        else         w_wdata[15:0]  = WriteData[15:0];
      end
      OP_SB: begin
        w_we = 1'b1;
        case (AO_M[1:0])
          2'd0:    w_wdata[7:0]   = WriteData[7:0];
          2'd1:    w_wdata[15:8]  = WriteData[7:0];
          2'd2:    w_wdata[23:16] = WriteData[7:0];
          default: w_wdata[31:24] = WriteData[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**DM_AW; i++) r_dm[i] <= '0;
    end else if (w_we) begin
      r_dm[w_idx] <= w_wdata;
    end
  end

  always_comb begin
    w_half = AO_M[1] ? w_word[31:16] : w_word[15:0];
    case (AO_M[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  // Non-load opcodes pass the raw addressed word; W ignores it.
  always_comb begin
    case (w_op)
      OP_LW:   w_ld = w_word;
      OP_LH:   w_ld = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ld = {16'h0, w_half};
      OP_LB:   w_ld = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ld = {24'h0, w_byte};
      default: w_ld = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IR_W  <= '0;
      AO_W  <= '0;
      DR_WD <= '0;
      PC8_W <= '0;
      A3_W  <= '0;
      Res_W <= '0;
    end else begin
      IR_W  <= IR_M;
      AO_W  <= AO_M;
      DR_WD <= w_ld;
      PC8_W <= PC8_M;
      A3_W  <= A3_M;
      Res_W <= Res_M;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: loads/stores of every width, wrap, pass-through, reset.
module tb_mem_wb_stage;
  logic        clk;
  logic        reset;
  logic [31:0] IR_M, AO_M, WriteData, PC8_M;
  logic [4:0]  A3_M;
  logic [1:0]  Res_M;
  logic [31:0] IR_W, AO_W, DR_WD, PC8_W;
  logic [4:0]  A3_W;
  logic [1:0]  Res_W;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101,
                         LB = 6'b100000, LBU = 6'b100100, SW = 6'b101011,
                         SH = 6'b101001, SB = 6'b101000, JAL = 6'b000011;

  mem_wb_stage #(.DM_AW(10)) dut (
    .clk(clk), .reset(reset), .IR_M(IR_M), .AO_M(AO_M), .WriteData(WriteData),
    .PC8_M(PC8_M), .A3_M(A3_M), .Res_M(Res_M), .IR_W(IR_W), .AO_W(AO_W),
    .DR_WD(DR_WD), .PC8_W(PC8_W), .A3_W(A3_W), .Res_W(Res_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] wd,
                       input logic [4:0] a3, input logic [1:0] res);
    IR_M      = {op, 26'h0000123};
    AO_M      = ao;
    WriteData = wd;
    PC8_M     = 32'h0000_3000 + ao;
    A3_M      = a3;
    Res_M     = res;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(JAL, 32'h10, 32'h55, 5'd3, 2'b01);
    cyc(); cyc();
    tests++;
    if ({IR_W, AO_W, DR_WD, PC8_W, A3_W, Res_W} !== '0) begin
      fails++;
      $display("FAIL reset_init outputs got %h/%h/%h/%h/%h/%h exp all 0",
               IR_W, AO_W, DR_WD, PC8_W, A3_W, Res_W);
    end
    reset = 1'b1;
    drive(LW, 32'h0, 32'h0, 5'd4, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0 || Res_W !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_lw DR_WD=%h Res_W=%b exp 0/10", DR_WD, Res_W);
    end
  endtask

  task automatic test_sw_lw;
    drive(SW, 32'h10, 32'h1234_5678, 5'd0, 2'b00);
    cyc();
    drive(LW, 32'h10, 32'h0, 5'd9, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h1234_5678 || Res_W !== 2'b10 || A3_W !== 5'd9) begin
      fails++;
      $display("FAIL sw_lw DR_WD=%h Res_W=%b A3_W=%0d exp 12345678/10/9", DR_WD, Res_W, A3_W);
    end
    tests++;
    if (IR_W !== {LW, 26'h0000123} || AO_W !== 32'h10) begin
      fails++;
      $display("FAIL sw_lw_regs IR_W=%h AO_W=%h exp %h/00000010", IR_W, AO_W, {LW, 26'h0000123});
    end
  endtask

  task automatic test_byte;
    drive(SW, 32'h20, 32'h1122_3344, 5'd0, 2'b00);
    cyc();
    drive(SB, 32'h21, 32'hFFFF_FFAB, 5'd0, 2'b00);
    cyc();
    drive(LW, 32'h20, 32'h0, 5'd1, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h1122_AB44) begin
      fails++;
      $display("FAIL sb_merge DR_WD=%h exp 1122ab44", DR_WD);
    end
    drive(LB, 32'h21, 32'h0, 5'd1, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'hFFFF_FFAB) begin
      fails++;
      $display("FAIL lb DR_WD=%h exp ffffffab", DR_WD);
    end
    drive(LBU, 32'h21, 32'h0, 5'd1, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0000_00AB) begin
      fails++;
      $display("FAIL lbu DR_WD=%h exp 000000ab", DR_WD);
    end
    drive(LBU, 32'h23, 32'h0, 5'd1, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0000_0011) begin
      fails++;
      $display("FAIL lbu_lane3 DR_WD=%h exp 00000011", DR_WD);
    end
  endtask

  task automatic test_half;
    drive(SW, 32'h30, 32'hDEAD_BEEF, 5'd0, 2'b00);
    cyc();
    drive(SH, 32'h33, 32'h7777_8001, 5'd0, 2'b00);
    cyc();
    drive(LH, 32'h32, 32'h0, 5'd2, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'hFFFF_8001) begin
      fails++;
      $display("FAIL lh DR_WD=%h exp ffff8001", DR_WD);
    end
    drive(LHU, 32'h32, 32'h0, 5'd2, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0000_8001) begin
      fails++;
      $display("FAIL lhu DR_WD=%h exp 00008001", DR_WD);
    end
    drive(LW, 32'h30, 32'h0, 5'd2, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h8001_BEEF) begin
      fails++;
      $display("FAIL sh_merge DR_WD=%h exp 8001beef", DR_WD);
    end
    drive(LH, 32'h30, 32'h0, 5'd2, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'hFFFF_BEEF) begin
      fails++;
      $display("FAIL lh_low DR_WD=%h exp ffffbeef", DR_WD);
    end
  endtask

  task automatic test_wrap;
    drive(SW, 32'h1004, 32'hCAFE_F00D, 5'd0, 2'b00);
    cyc();
    drive(LW, 32'h4, 32'h0, 5'd5, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL wrap DR_WD=%h exp cafef00d", DR_WD);
    end
  endtask

  task automatic test_passthru;
    drive(JAL, 32'h10, 32'hBAD0_BAD0, 5'd31, 2'b11);
    PC8_M = 32'h3008;
    cyc();
    tests++;
    if (PC8_W !== 32'h3008 || A3_W !== 5'd31 || Res_W !== 2'b11 || DR_WD !== 32'h1234_5678) begin
      fails++;
      $display("FAIL passthru PC8_W=%h A3_W=%0d Res_W=%b DR_WD=%h exp 3008/31/11/12345678",
               PC8_W, A3_W, Res_W, DR_WD);
    end
    drive(LW, 32'h10, 32'h0, 5'd6, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h1234_5678) begin
      fails++;
      $display("FAIL passthru_nowrite DR_WD=%h exp 12345678", DR_WD);
    end
  endtask

  task automatic test_reset_midrun;
    drive(SW, 32'h10, 32'hFFFF_FFFF, 5'd7, 2'b01);
    cyc();
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({IR_W, AO_W, DR_WD, PC8_W, A3_W, Res_W} !== '0) begin
      fails++;
      $display("FAIL reset_async outputs got %h/%h/%h/%h/%h/%h exp all 0",
               IR_W, AO_W, DR_WD, PC8_W, A3_W, Res_W);
    end
    cyc(); cyc();
    drive(LW, 32'h10, 32'h0, 5'd8, 2'b10);
    #1 reset = 1'b1;
    cyc();
    tests++;
    if (DR_WD !== 32'h0 || A3_W !== 5'd8) begin
      fails++;
      $display("FAIL reset_clear_mem DR_WD=%h A3_W=%0d exp 0/8", DR_WD, A3_W);
    end
    drive(LW, 32'h0, 32'h0, 5'd8, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0) begin
      fails++;
      $display("FAIL reset_lw0 DR_WD=%h exp 0", DR_WD);
    end
  endtask

  task automatic test_back_to_back;
    drive(SB, 32'h40, 32'h0000_0012, 5'd0, 2'b00);
    cyc();
    drive(SB, 32'h42, 32'h0000_0034, 5'd0, 2'b00);
    cyc();
    drive(LW, 32'h40, 32'h0, 5'd10, 2'b10);
    cyc();
    tests++;
    if (DR_WD !== 32'h0034_0012) begin
      fails++;
      $display("FAIL b2b_sb DR_WD=%h exp 00340012", DR_WD);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(JAL, 32'h0, 32'h0, 5'd0, 2'b00);
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_wrap();
    test_passthru();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline plus the M/W pipeline register.
- Consumes the forwarded store data WriteData, the M-stage ALU result and the instruction word.
- Performs word, halfword and byte loads and stores on an internal data memory.
- Registers everything the W stage and the W→M store-data forwarding path need: AO_W, DR_WD, A3_W, Res_W, PC8_W.

Parameters:
- DM_AW, 10: word-address width; memory depth is 2^DM_AW 32-bit words, indexed by AO_M[DM_AW+1:2].

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- IR_M  in  32  M-stage instruction word.
- AO_M  in  32  M-stage ALU result; also the memory byte address.
- WriteData  in  32  forwarded rt value used as store data.
- PC8_M  in  32  M-stage PC+8.
- A3_M  in  5  M-stage destination register number.
- Res_M  in  2  M-stage result source: 00 none, 01 ALU, 10 DM, 11 PC.
- IR_W  out  32  registered IR_M.
- AO_W  out  32  registered AO_M.
- DR_WD  out  32  registered, extended load data.
- PC8_W  out  32  registered PC8_M.
- A3_W  out  5  registered A3_M.
- Res_W  out  2  registered Res_M.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - All outputs go to 0; Res_W=00 means no write.
  - Every memory word is cleared to 0.
  - No store may occur while reset is low.
- Deassertion: the first rising edge with reset=1 captures M-stage inputs normally.
- Decode uses IR_M[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - sw 101011, sh 101001, sb 101000.
  - Any other opcode is neither a load nor a store.
- Word index is AO_M[DM_AW+1:2]. Address bits above DM_AW+1 are ignored, so addresses wrap modulo the memory size.
- Stores are synchronous and write on the rising edge at the end of the M cycle:
  - sw: writes the whole word; AO_M[1:0] ignored.
  - sh: writes WriteData[15:0] to half AO_M[1] (0 → bits 15:0, 1 → bits 31:16); AO_M[0] ignored.
  - sb: writes WriteData[7:0] to byte lane AO_M[1:0] (lane 0 = bits 7:0).
  - Unwritten bytes of the word keep their values.
- Loads are combinational from the array during M and extended before registering:
  - lw: whole word.
  - lh / lhu: half selected by AO_M[1], sign-extended / zero-extended.
  - lb / lbu: byte selected by AO_M[1:0], sign-extended / zero-extended.
  - Non-load instructions: DR_WD still captures the raw addressed word (don't-care downstream).
- Latency: all W outputs are valid exactly one cycle after the instruction occupies M.
- No stall or flush input: the register advances every cycle.
- Store then load to the same word in consecutive cycles: the load reads the updated contents.
- No alignment exceptions: misaligned low address bits are handled only as the lane selection above.
- Store data is always WriteData as given; this block does no forwarding of its own.

Test Plan:
- Reset low mid-run with nonzero inputs → all outputs 0 immediately; after release, lw from address 0x0 gives DR_WD=0.
- sw WriteData=0x12345678 at AO_M=0x10, next cycle lw 0x10 → one cycle later DR_WD=0x12345678, Res_W=10, A3_W=captured A3_M.
- Word 0x20 preset to 0x11223344; sb WriteData=0xAB at 0x21 → word becomes 0x1122AB44. Then lb 0x21 → 0xFFFFFFAB; lbu 0x21 → 0x000000AB.
- sh WriteData=0x8001 at 0x32, then lh 0x32 → 0xFFFF8001, lhu 0x32 → 0x00008001, lw 0x30 → 0x8001xxxx with the lower half unchanged.
- Wrap: with DM_AW=10, sw 0xCAFEF00D at AO_M=0x1004, then lw 0x4 → 0xCAFEF00D.
- Pass-through: jal-type inputs PC8_M=0x3008, A3_M=31, Res_M=11 → one cycle later PC8_W=0x3008, A3_W=31, Res_W=11, and no memory word changes.
